// File: rtl/compare_seq_ctrl.sv
// Digit-serial unsigned magnitude compare built on one 2-bit slice.
// Digits are fed MSB first; the walk stops at the first unequal digit.
module compare2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    lt = 1'b0;
    unique case (1'b1)
      (x > y):  gt = 1'b1;
      (x == y): eq = 1'b1;
      default:  lt = 1'b1;
    endcase
  end

endmodule

module compare_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CLAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]  cnt;
  logic           s_gt;
  logic           s_eq;
  logic           s_lt;

  // The slice only ever sees the top digit of the shifting operands.
  compare2 u_slice (
    .x  (sa[WIDTH-1 -: 2]),
    .y  (sb[WIDTH-1 -: 2]),
    .gt (s_gt),
    .eq (s_eq),
    .lt (s_lt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            cnt   <= CLAST;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (!s_eq) begin
            gt    <= s_gt;
            lt    <= s_lt;
            eq    <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt == '0) begin
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sa  <= sa << 2;
            sb  <= sb << 2;
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
